hella_cache_arb2: RTL and testbench

Two-requester arbiter that shares a single HellaCache port between two clients, e.g. core data path and page-table walker. It grants one request per cycle, appends a 1-bit requester ID to the tag, and tracks the in-flight request through the s1/s2 stages. It routes kill and data inputs from the owning requester, and routes nack and resp outputs back to that requester.

---
 rtl/hella_cache_arb2_if.sv | 96 +++++++++
 rtl/hella_cache_arb2.sv | 89 ++++++++
 tb/tb_hella_cache_arb2.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hella_cache_arb2_if.sv
// Signal bundle between the two HellaCache clients, the arbiter and the shared cache port.
// No logic; master = arbiter side, slave = clients plus cache.
// Handshake is valid/ready on req; s1/s2 kills and nacks are positional, with no handshake.
interface hella_cache_arb2_if #(
  parameter int TAG_W  = 7,
  parameter int ADDR_W = 40
);
  logic              requestor_0_req_ready;
  logic              requestor_0_req_valid;
  logic [ADDR_W-1:0] requestor_0_req_bits_addr;
  logic [TAG_W-1:0]  requestor_0_req_bits_tag;
  logic [4:0]        requestor_0_req_bits_cmd;
  logic [1:0]        requestor_0_req_bits_size;
  logic [63:0]       requestor_0_req_bits_data;
  logic [7:0]        requestor_0_req_bits_mask;
  logic              requestor_0_s1_kill;
  logic [63:0]       requestor_0_s1_data_data;
  logic [7:0]        requestor_0_s1_data_mask;
  logic              requestor_0_s2_kill;
  logic              requestor_0_s2_nack;
  logic              requestor_0_resp_valid;
  logic [TAG_W-1:0]  requestor_0_resp_bits_tag;
  logic [63:0]       requestor_0_resp_bits_data;

  logic              requestor_1_req_ready;
  logic              requestor_1_req_valid;
  logic [ADDR_W-1:0] requestor_1_req_bits_addr;
  logic [TAG_W-1:0]  requestor_1_req_bits_tag;
  logic [4:0]        requestor_1_req_bits_cmd;
  logic [1:0]        requestor_1_req_bits_size;
  logic [63:0]       requestor_1_req_bits_data;
  logic [7:0]        requestor_1_req_bits_mask;
  logic              requestor_1_s1_kill;
  logic [63:0]       requestor_1_s1_data_data;
  logic [7:0]        requestor_1_s1_data_mask;
  logic              requestor_1_s2_kill;
  logic              requestor_1_s2_nack;
  logic              requestor_1_resp_valid;
  logic [TAG_W-1:0]  requestor_1_resp_bits_tag;
  logic [63:0]       requestor_1_resp_bits_data;

  logic              mem_req_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_bits_addr;
  logic [TAG_W:0]    mem_req_bits_tag;
  logic [4:0]        mem_req_bits_cmd;
  logic [1:0]        mem_req_bits_size;
  logic [63:0]       mem_req_bits_data;
  logic [7:0]        mem_req_bits_mask;
  logic              mem_s1_kill;
  logic [63:0]       mem_s1_data_data;
  logic [7:0]        mem_s1_data_mask;
  logic              mem_s2_kill;
  logic              mem_s2_nack;
  logic              mem_resp_valid;
  logic [TAG_W:0]    mem_resp_bits_tag;
  logic [63:0]       mem_resp_bits_data;

  modport master (
    output requestor_0_req_ready, requestor_0_s2_nack, requestor_0_resp_valid,
           requestor_0_resp_bits_tag, requestor_0_resp_bits_data,
    input  requestor_0_req_valid, requestor_0_req_bits_addr, requestor_0_req_bits_tag,
           requestor_0_req_bits_cmd, requestor_0_req_bits_size, requestor_0_req_bits_data,
           requestor_0_req_bits_mask, requestor_0_s1_kill, requestor_0_s1_data_data,
           requestor_0_s1_data_mask, requestor_0_s2_kill,
    output requestor_1_req_ready, requestor_1_s2_nack, requestor_1_resp_valid,
           requestor_1_resp_bits_tag, requestor_1_resp_bits_data,
    input  requestor_1_req_valid, requestor_1_req_bits_addr, requestor_1_req_bits_tag,
           requestor_1_req_bits_cmd, requestor_1_req_bits_size, requestor_1_req_bits_data,
           requestor_1_req_bits_mask, requestor_1_s1_kill, requestor_1_s1_data_data,
           requestor_1_s1_data_mask, requestor_1_s2_kill,
    output mem_req_valid, mem_req_bits_addr, mem_req_bits_tag, mem_req_bits_cmd,
           mem_req_bits_size, mem_req_bits_data, mem_req_bits_mask, mem_s1_kill,
           mem_s1_data_data, mem_s1_data_mask, mem_s2_kill,
    input  mem_req_ready, mem_s2_nack, mem_resp_valid, mem_resp_bits_tag, mem_resp_bits_data
  );

  modport slave (
    input  requestor_0_req_ready, requestor_0_s2_nack, requestor_0_resp_valid,
           requestor_0_resp_bits_tag, requestor_0_resp_bits_data,
    output requestor_0_req_valid, requestor_0_req_bits_addr, requestor_0_req_bits_tag,
           requestor_0_req_bits_cmd, requestor_0_req_bits_size, requestor_0_req_bits_data,
           requestor_0_req_bits_mask, requestor_0_s1_kill, requestor_0_s1_data_data,
           requestor_0_s1_data_mask, requestor_0_s2_kill,
    input  requestor_1_req_ready, requestor_1_s2_nack, requestor_1_resp_valid,
           requestor_1_resp_bits_tag, requestor_1_resp_bits_data,
    output requestor_1_req_valid, requestor_1_req_bits_addr, requestor_1_req_bits_tag,
           requestor_1_req_bits_cmd, requestor_1_req_bits_size, requestor_1_req_bits_data,
           requestor_1_req_bits_mask, requestor_1_s1_kill, requestor_1_s1_data_data,
           requestor_1_s1_data_mask, requestor_1_s2_kill,
    input  mem_req_valid, mem_req_bits_addr, mem_req_bits_tag, mem_req_bits_cmd,
           mem_req_bits_size, mem_req_bits_data, mem_req_bits_mask, mem_s1_kill,
           mem_s1_data_data, mem_s1_data_mask, mem_s2_kill,
    output mem_req_ready, mem_s2_nack, mem_resp_valid, mem_resp_bits_tag, mem_resp_bits_data
  );
endinterface

// File: rtl/hella_cache_arb2.sv
// Two-client HellaCache arbiter: fixed 0>1 priority, or round-robin when HCARB_RR_EN is defined.
// Latency: grant, request and response are combinational; s1/s2 sideband follows the fire by 1 and 2 cycles.
// Backpressure: cache req_ready goes only to the selected client; the grant holds while ready is low.
module hella_cache_arb2 #(
  parameter int TAG_W  = 7,
  parameter int ADDR_W = 40
) (
  input  logic                clock,
  input  logic                reset,
  hella_cache_arb2_if.master  io
);

  logic v0, v1, sel, fire;
  logic s1_v, s1_id, s2_v, s2_id;
  logic resp_id;
`ifdef HCARB_RR_EN
  logic rr_last;
`endif

  always_comb begin
    v0 = reset & io.requestor_0_req_valid;
    v1 = reset & io.requestor_1_req_valid;
`ifdef HCARB_RR_EN
    sel = (v0 & v1) ? ~rr_last : ~v0;
`else
    sel = ~v0;
`endif
    fire = (v0 | v1) & io.mem_req_ready;
  end

  // Request side: only the selected client sees the cache's ready
  always_comb begin
    io.mem_req_valid         = v0 | v1;
    io.requestor_0_req_ready = reset & io.mem_req_ready & ~sel;
    io.requestor_1_req_ready = reset & io.mem_req_ready & sel;
    io.mem_req_bits_addr     = sel ? io.requestor_1_req_bits_addr : io.requestor_0_req_bits_addr;
    io.mem_req_bits_tag      = {(sel ? io.requestor_1_req_bits_tag : io.requestor_0_req_bits_tag), sel};
    io.mem_req_bits_cmd      = sel ? io.requestor_1_req_bits_cmd  : io.requestor_0_req_bits_cmd;
    io.mem_req_bits_size     = sel ? io.requestor_1_req_bits_size : io.requestor_0_req_bits_size;
    io.mem_req_bits_data     = sel ? io.requestor_1_req_bits_data : io.requestor_0_req_bits_data;
    io.mem_req_bits_mask     = sel ? io.requestor_1_req_bits_mask : io.requestor_0_req_bits_mask;
  end

  // Killed requests still advance so a later nack reaches the right owner
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_v  <= 1'b0;
      s1_id <= 1'b0;
      s2_v  <= 1'b0;
      s2_id <= 1'b0;
    end else begin
      s1_v  <= fire;
      s1_id <= sel;
      s2_v  <= s1_v;
      s2_id <= s1_id;
    end
  end

`ifdef HCARB_RR_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_last <= 1'b1;
    end else if (fire) begin
      rr_last <= sel;
    end
  end
`endif

  always_comb begin
    io.mem_s1_kill      = s1_v & (s1_id ? io.requestor_1_s1_kill : io.requestor_0_s1_kill);
    io.mem_s1_data_data = s1_id ? io.requestor_1_s1_data_data : io.requestor_0_s1_data_data;
    io.mem_s1_data_mask = s1_id ? io.requestor_1_s1_data_mask : io.requestor_0_s1_data_mask;
    io.mem_s2_kill      = s2_v & (s2_id ? io.requestor_1_s2_kill : io.requestor_0_s2_kill);
    io.requestor_0_s2_nack = s2_v & ~s2_id & io.mem_s2_nack;
    io.requestor_1_s2_nack = s2_v & s2_id & io.mem_s2_nack;
  end

  // Responses are routed purely by the tag LSB, independent of tracking state
  always_comb begin
    resp_id = io.mem_resp_bits_tag[0];
    io.requestor_0_resp_valid     = io.mem_resp_valid & ~resp_id;
    io.requestor_1_resp_valid     = io.mem_resp_valid & resp_id;
    io.requestor_0_resp_bits_tag  = io.mem_resp_bits_tag[TAG_W:1];
    io.requestor_1_resp_bits_tag  = io.mem_resp_bits_tag[TAG_W:1];
    io.requestor_0_resp_bits_data = io.mem_resp_bits_data;
    io.requestor_1_resp_bits_data = io.mem_resp_bits_data;
  end

endmodule

// File: tb/tb_hella_cache_arb2.sv
// Directed bench for hella_cache_arb2: vector table for grant/response muxing,
// hand sequences for nack, contention, stall, kill routing and reset.
module tb_hella_cache_arb2;
  localparam int TAG_W  = 7;
  localparam int ADDR_W = 40;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hella_cache_arb2_if #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) io ();
  hella_cache_arb2 #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io.master)
  );

  typedef struct {
    logic        v0, v1, mready;
    logic [6:0]  tag0, tag1;
    logic        rv;
    logic [7:0]  rtag;
    logic [63:0] rdata;
    logic        e_mv, e_rdy0, e_rdy1;
    logic [7:0]  e_mtag;
    logic        e_rv0, e_rv1;
    logic [6:0]  e_rtag;
  } vec_t;

  vec_t vecs [8];
  int n_cmp = 0;
  int n_err = 0;
`ifdef HCARB_RR_EN
  logic [3:0] exp_sel = 4'b1010;
  logic       exp_after_stall = 1'b1;
`else
  logic [3:0] exp_sel = 4'b0000;
  logic       exp_after_stall = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    io.requestor_0_req_valid = 0; io.requestor_0_req_bits_addr = '0; io.requestor_0_req_bits_tag = '0;
    io.requestor_0_req_bits_cmd = '0; io.requestor_0_req_bits_size = '0; io.requestor_0_req_bits_data = '0;
    io.requestor_0_req_bits_mask = '0; io.requestor_0_s1_kill = 0; io.requestor_0_s1_data_data = '0;
    io.requestor_0_s1_data_mask = '0; io.requestor_0_s2_kill = 0;
    io.requestor_1_req_valid = 0; io.requestor_1_req_bits_addr = '0; io.requestor_1_req_bits_tag = '0;
    io.requestor_1_req_bits_cmd = '0; io.requestor_1_req_bits_size = '0; io.requestor_1_req_bits_data = '0;
    io.requestor_1_req_bits_mask = '0; io.requestor_1_s1_kill = 0; io.requestor_1_s1_data_data = '0;
    io.requestor_1_s1_data_mask = '0; io.requestor_1_s2_kill = 0;
    io.mem_req_ready = 0; io.mem_s2_nack = 0; io.mem_resp_valid = 0;
    io.mem_resp_bits_tag = '0; io.mem_resp_bits_data = '0;
  endtask

  initial begin
    //            v0 v1 mr tag0   tag1   rv rtag   rdata                  mv r0 r1 mtag   rv0 rv1 rtag
    vecs[0] = '{0, 0, 1, 7'h05, 7'h15, 0, 8'h00, 64'h0,                0, 0, 1, 8'h2B, 0, 0, 7'h00};
    vecs[1] = '{1, 0, 1, 7'h05, 7'h15, 0, 8'h00, 64'h0,                1, 1, 0, 8'h0A, 0, 0, 7'h00};
    vecs[2] = '{0, 1, 1, 7'h05, 7'h15, 0, 8'h00, 64'h0,                1, 0, 1, 8'h2B, 0, 0, 7'h00};
    vecs[3] = '{1, 0, 0, 7'h33, 7'h15, 0, 8'h00, 64'h0,                1, 0, 0, 8'h66, 0, 0, 7'h00};
    vecs[4] = '{0, 1, 0, 7'h33, 7'h7F, 0, 8'h00, 64'h0,                1, 0, 0, 8'hFF, 0, 0, 7'h00};
    vecs[5] = '{0, 0, 0, 7'h00, 7'h00, 1, 8'h2B, 64'hDEADBEEF,         0, 0, 0, 8'h01, 0, 1, 7'h15};
    vecs[6] = '{0, 0, 0, 7'h00, 7'h00, 1, 8'h0A, 64'h0123456789ABCDEF, 0, 0, 0, 8'h01, 1, 0, 7'h05};
    vecs[7] = '{0, 0, 0, 7'h00, 7'h00, 0, 8'hFF, 64'h55,               0, 0, 0, 8'h01, 0, 0, 7'h7F};

    // Reset with every input trying to provoke activity
    idle();
    reset = 0;
    io.requestor_0_req_valid = 1; io.requestor_1_req_valid = 1; io.mem_req_ready = 1;
    io.requestor_0_s1_kill = 1; io.requestor_1_s1_kill = 1;
    io.requestor_0_s2_kill = 1; io.requestor_1_s2_kill = 1; io.mem_s2_nack = 1;
    tick();
    #4;
    chk("rst_mem_valid", io.mem_req_valid, 0);
    chk("rst_rdy0", io.requestor_0_req_ready, 0);
    chk("rst_rdy1", io.requestor_1_req_ready, 0);
    chk("rst_s1_kill", io.mem_s1_kill, 0);
    chk("rst_s2_kill", io.mem_s2_kill, 0);
    chk("rst_nack0", io.requestor_0_s2_nack, 0);
    chk("rst_nack1", io.requestor_1_s2_nack, 0);
    tick();
    reset = 1;
    idle();
    tick();

    for (int i = 0; i < 8; i++) begin
      io.requestor_0_req_valid = vecs[i].v0;
      io.requestor_1_req_valid = vecs[i].v1;
      io.mem_req_ready = vecs[i].mready;
      io.requestor_0_req_bits_tag = vecs[i].tag0;
      io.requestor_1_req_bits_tag = vecs[i].tag1;
      io.mem_resp_valid = vecs[i].rv;
      io.mem_resp_bits_tag = vecs[i].rtag;
      io.mem_resp_bits_data = vecs[i].rdata;
      #4;
      chk($sformatf("v%0d_mem_valid", i), io.mem_req_valid, vecs[i].e_mv);
      chk($sformatf("v%0d_rdy0", i), io.requestor_0_req_ready, vecs[i].e_rdy0);
      chk($sformatf("v%0d_rdy1", i), io.requestor_1_req_ready, vecs[i].e_rdy1);
      chk($sformatf("v%0d_mem_tag", i), io.mem_req_bits_tag, vecs[i].e_mtag);
      chk($sformatf("v%0d_resp_v0", i), io.requestor_0_resp_valid, vecs[i].e_rv0);
      chk($sformatf("v%0d_resp_v1", i), io.requestor_1_resp_valid, vecs[i].e_rv1);
      chk($sformatf("v%0d_resp_tag0", i), io.requestor_0_resp_bits_tag, vecs[i].e_rtag);
      chk($sformatf("v%0d_resp_tag1", i), io.requestor_1_resp_bits_tag, vecs[i].e_rtag);
      chk($sformatf("v%0d_resp_data1", i), io.requestor_1_resp_bits_data, vecs[i].rdata);
      tick();
    end
    idle();
    tick();

    // Single request from client 1, then its nack two cycles later
    io.requestor_1_req_valid = 1; io.requestor_1_req_bits_tag = 7'h15;
    io.requestor_1_req_bits_addr = 40'h80001000; io.requestor_1_req_bits_cmd = 5'h01;
    io.mem_req_ready = 1; io.mem_s2_nack = 1;
    #4;
    chk("single_tag", io.mem_req_bits_tag, 8'h2B);
    chk("single_addr", io.mem_req_bits_addr, 40'h80001000);
    chk("single_cmd", io.mem_req_bits_cmd, 5'h01);
    chk("single_rdy1", io.requestor_1_req_ready, 1);
    chk("single_t0_nack1", io.requestor_1_s2_nack, 0);
    tick();
    idle(); io.mem_s2_nack = 1;
    #4;
    chk("single_t1_nack1", io.requestor_1_s2_nack, 0);
    tick();
    io.mem_s2_nack = 1;
    #4;
    chk("single_t2_nack1", io.requestor_1_s2_nack, 1);
    chk("single_t2_nack0", io.requestor_0_s2_nack, 0);
    tick();
    idle();

    // Contention from a fresh reset
    reset = 0;
    tick();
    reset = 1;
    io.requestor_0_req_valid = 1; io.requestor_0_req_bits_tag = 7'h01; io.requestor_0_req_bits_addr = 40'h100;
    io.requestor_1_req_valid = 1; io.requestor_1_req_bits_tag = 7'h02; io.requestor_1_req_bits_addr = 40'h200;
    io.mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk($sformatf("cont%0d_rdy0", i), io.requestor_0_req_ready, !exp_sel[i]);
      chk($sformatf("cont%0d_rdy1", i), io.requestor_1_req_ready, exp_sel[i]);
      chk($sformatf("cont%0d_tag", i), io.mem_req_bits_tag, exp_sel[i] ? 8'h05 : 8'h02);
      tick();
    end

    // Stall with both still valid; grant must hold and nothing enters s1
    io.mem_req_ready = 0;
    io.requestor_0_s1_kill = 1; io.requestor_1_s1_kill = 1;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk($sformatf("stall%0d_valid", i), io.mem_req_valid, 1);
      chk($sformatf("stall%0d_rdy0", i), io.requestor_0_req_ready, 0);
      chk($sformatf("stall%0d_rdy1", i), io.requestor_1_req_ready, 0);
      chk($sformatf("stall%0d_addr", i), io.mem_req_bits_addr, 40'h100);
      chk($sformatf("stall%0d_s1_kill", i), io.mem_s1_kill, (i == 0) ? 1'b1 : 1'b0);
      tick();
    end
    io.mem_req_ready = 1;
    io.requestor_0_s1_kill = 0; io.requestor_1_s1_kill = 0;
    #4;
    chk("resume0_rdy0", io.requestor_0_req_ready, 1);
    tick();
    #4;
    chk("resume1_rdy1", io.requestor_1_req_ready, exp_after_stall);
    tick();
    idle();
    tick();
    tick();

    // Kill routing: client 0 fires at t, client 1 at t+1
    io.requestor_0_s1_data_data = 64'hAAAA; io.requestor_0_s1_data_mask = 8'h0F;
    io.requestor_1_s1_data_data = 64'hBBBB; io.requestor_1_s1_data_mask = 8'hF0;
    io.requestor_0_req_valid = 1; io.mem_req_ready = 1;
    tick();
    io.requestor_0_req_valid = 0; io.requestor_1_req_valid = 1; io.requestor_0_s1_kill = 1;
    #4;
    chk("kill_t1_s1_kill", io.mem_s1_kill, 1);
    chk("kill_t1_s1_data", io.mem_s1_data_data, 64'hAAAA);
    chk("kill_t1_s1_mask", io.mem_s1_data_mask, 8'h0F);
    tick();
    io.requestor_1_req_valid = 0; io.requestor_1_s1_kill = 0;
    #4;
    chk("kill_t2_s1_kill", io.mem_s1_kill, 0);
    chk("kill_t2_s1_data", io.mem_s1_data_data, 64'hBBBB);
    chk("kill_t2_s2_kill", io.mem_s2_kill, 0);
    tick();
    io.requestor_0_s1_kill = 0; io.requestor_1_s2_kill = 1;
    #4;
    chk("kill_t3_s2_kill", io.mem_s2_kill, 1);
    tick();
    idle();
    tick();
    tick();

    // Reset right after a fire; responses still route during reset
    io.requestor_0_req_valid = 1; io.mem_req_ready = 1;
    tick();
    reset = 0;
    io.requestor_1_req_valid = 1; io.requestor_0_s1_kill = 1;
    io.mem_resp_valid = 1; io.mem_resp_bits_tag = 8'h0A; io.mem_resp_bits_data = 64'h1234;
    #4;
    chk("mid_rst_rdy0", io.requestor_0_req_ready, 0);
    chk("mid_rst_rdy1", io.requestor_1_req_ready, 0);
    chk("mid_rst_valid", io.mem_req_valid, 0);
    chk("mid_rst_resp_v0", io.requestor_0_resp_valid, 1);
    chk("mid_rst_resp_tag0", io.requestor_0_resp_bits_tag, 7'h05);
    chk("mid_rst_resp_data0", io.requestor_0_resp_bits_data, 64'h1234);
    tick();
    reset = 1;
    idle();
    io.requestor_0_s1_kill = 1; io.requestor_0_s2_kill = 1; io.mem_s2_nack = 1;
    #4;
    chk("post_rst_s1_kill", io.mem_s1_kill, 0);
    chk("post_rst_s2_kill", io.mem_s2_kill, 0);
    chk("post_rst_nack0", io.requestor_0_s2_nack, 0);
    chk("post_rst_nack1", io.requestor_1_s2_nack, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
